// File: rtl/zhiwen_seq.sv
// Fingerprint-reader command sequencer: touch qualification,
// command kick-off, reply wait with timeout, and failure lockout.
module zhiwen_seq #(
    parameter int unsigned SETTLE_CYC  = 50_000_000,
    parameter int unsigned TIMEOUT_CYC = 150_000_000,
    parameter int unsigned MAX_FAIL    = 3,
    parameter int unsigned LOCK_CYC    = 500_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       chumo,
    input  logic       zhongzhi,
    input  logic       over_all,
    input  logic       tx_done,
    input  logic       rx_valid,
    input  logic       rx_match,
    output logic       tx_en,
    output logic       unlock,
    output logic       locked,
    output logic       busy,
    output logic [2:0] fail_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_SEND,
        S_WAIT,
        S_RELEASE,
        S_LOCK
    } state_t;

    state_t      state;
    state_t      nxt;
    logic [31:0] timer;
    logic        chumo_m;
    logic        chumo_s;
    logic [2:0]  fail_inc;
    logic [2:0]  fail_nxt;
    logic        fail_ev;
    logic        unlock_nxt;
    logic        settle_end;
    logic        resp_end;
    logic        lock_end;

    assign fail_inc   = fail_cnt + 3'd1;
    assign settle_end = (timer == SETTLE_CYC - 1);
    assign resp_end   = (timer == TIMEOUT_CYC - 1);
    assign lock_end   = (timer == LOCK_CYC - 1);

    // Next-state decision; abort outranks every same-cycle event
    always_comb begin
        nxt        = state;
        fail_nxt   = fail_cnt;
        fail_ev    = 1'b0;
        unlock_nxt = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (over_all)
                    nxt = S_IDLE;
                else if (zhongzhi)
                    nxt = S_SEND;
                else if (chumo_s)
                    nxt = S_SETTLE;
            end
            S_SETTLE: begin
                if (over_all || !chumo_s)
                    nxt = S_IDLE;
                else if (settle_end)
                    nxt = S_SEND;
            end
            S_SEND: begin
                if (over_all)
                    nxt = S_IDLE;
                else if (tx_done)
                    nxt = S_WAIT;
                else if (resp_end)
                    fail_ev = 1'b1;
            end
            S_WAIT: begin
                if (over_all) begin
                    nxt = S_IDLE;
                end else if (rx_valid && rx_match) begin
                    unlock_nxt = 1'b1;
                    fail_nxt   = 3'd0;
                    nxt        = S_RELEASE;
                end else if (rx_valid || resp_end) begin
                    fail_ev = 1'b1;
                end
            end
            S_RELEASE: begin
                if (over_all || !chumo_s)
                    nxt = S_IDLE;
            end
            S_LOCK: begin
                if (lock_end) begin
                    fail_nxt = 3'd0;
                    nxt      = S_RELEASE;
                end
            end
            default: nxt = S_IDLE;
        endcase
        if (fail_ev) begin
            fail_nxt = fail_inc;
            if (fail_inc == 3'(MAX_FAIL))
                nxt = S_LOCK;
            else
                nxt = S_RELEASE;
        end
    end

    // State, timer, touch synchroniser and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            timer    <= 32'd0;
            chumo_m  <= 1'b0;
            chumo_s  <= 1'b0;
            fail_cnt <= 3'd0;
            tx_en    <= 1'b0;
            unlock   <= 1'b0;
            locked   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            chumo_m  <= chumo;
            chumo_s  <= chumo_m;
            state    <= nxt;
            fail_cnt <= fail_nxt;
            timer    <= (nxt != state) ? 32'd0 : timer + 32'd1;
            tx_en    <= (nxt == S_SEND) && (state != S_SEND);
            unlock   <= unlock_nxt;
            locked   <= (nxt == S_LOCK);
            busy     <= (nxt != S_IDLE);
        end
    end

endmodule

// File: tb/tb_zhiwen_seq.sv
// Bench for zhiwen_seq: vector table, directed corner sequences,
// and random traffic against a mode/cycle-count reference model.
module tb_zhiwen_seq;

    localparam int SETTLE_CYC  = 10;
    localparam int TIMEOUT_CYC = 20;
    localparam int MAX_FAIL    = 3;
    localparam int LOCK_CYC    = 50;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       chumo = 1'b0;
    logic       zhongzhi = 1'b0;
    logic       over_all = 1'b0;
    logic       tx_done = 1'b0;
    logic       rx_valid = 1'b0;
    logic       rx_match = 1'b0;
    logic       tx_en;
    logic       unlock;
    logic       locked;
    logic       busy;
    logic [2:0] fail_cnt;

    int n_pass = 0;
    int n_total = 0;

    zhiwen_seq #(
        .SETTLE_CYC (SETTLE_CYC),
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .MAX_FAIL   (MAX_FAIL),
        .LOCK_CYC   (LOCK_CYC)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .chumo   (chumo),
        .zhongzhi(zhongzhi),
        .over_all(over_all),
        .tx_done (tx_done),
        .rx_valid(rx_valid),
        .rx_match(rx_match),
        .tx_en   (tx_en),
        .unlock  (unlock),
        .locked  (locked),
        .busy    (busy),
        .fail_cnt(fail_cnt)
    );

    always #5 clk = ~clk;

    function automatic void check(string nm, int act, int exp);
        n_total++;
        if (act == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, act, exp, $time);
    endfunction

    // Reference model: named mode plus cycles spent in it
    string m_mode = "IDLE";
    int    m_spent = 0;
    int    m_fails = 0;
    bit    m_syn1 = 0;
    bit    m_syn2 = 0;
    bit    e_tx = 0;
    bit    e_unlock = 0;
    bit    e_locked = 0;
    bit    e_busy = 0;

    function automatic void model_step();
        string nm;
        bit    fail_now;
        bit    touch;
        int    cyc;
        if (!rst_n) begin
            m_mode = "IDLE";
            m_spent = 0;
            m_fails = 0;
            m_syn1 = 0;
            m_syn2 = 0;
            e_tx = 0;
            e_unlock = 0;
            e_locked = 0;
            e_busy = 0;
            return;
        end
        touch = m_syn2;
        cyc = m_spent + 1;
        nm = m_mode;
        fail_now = 0;
        e_unlock = 0;
        if (over_all && m_mode != "LOCKOUT") begin
            nm = "IDLE";
        end else if (m_mode == "IDLE") begin
            if (zhongzhi) nm = "SEND";
            else if (touch) nm = "SETTLE";
        end else if (m_mode == "SETTLE") begin
            if (!touch) nm = "IDLE";
            else if (cyc == SETTLE_CYC) nm = "SEND";
        end else if (m_mode == "SEND") begin
            if (tx_done) nm = "WAIT";
            else if (cyc == TIMEOUT_CYC) fail_now = 1;
        end else if (m_mode == "WAIT") begin
            if (rx_valid && rx_match) begin
                e_unlock = 1;
                m_fails = 0;
                nm = "RELEASE";
            end else if (rx_valid || cyc == TIMEOUT_CYC) begin
                fail_now = 1;
            end
        end else if (m_mode == "RELEASE") begin
            if (!touch) nm = "IDLE";
        end else if (m_mode == "LOCKOUT") begin
            if (cyc == LOCK_CYC) begin
                m_fails = 0;
                nm = "RELEASE";
            end
        end
        if (fail_now) begin
            m_fails++;
            nm = (m_fails == MAX_FAIL) ? "LOCKOUT" : "RELEASE";
        end
        e_tx = (nm == "SEND") && (m_mode != "SEND");
        m_spent = (nm == m_mode) ? cyc : 0;
        m_mode = nm;
        e_locked = (nm == "LOCKOUT");
        e_busy = (nm != "IDLE");
        m_syn2 = m_syn1;
        m_syn1 = chumo;
    endfunction

    always @(posedge clk) model_step();

    // Every cycle, all outputs against the model
    always @(negedge clk) begin
        check("m_tx_en", int'(tx_en), int'(e_tx));
        check("m_unlock", int'(unlock), int'(e_unlock));
        check("m_locked", int'(locked), int'(e_locked));
        check("m_busy", int'(busy), int'(e_busy));
        check("m_fail_cnt", int'(fail_cnt), m_fails);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic scan(input bit m);
        zhongzhi = 1;
        step();
        zhongzhi = 0;
        step();
        tx_done = 1;
        step();
        tx_done = 0;
        rx_valid = 1;
        rx_match = m;
        step();
        rx_valid = 0;
        rx_match = 0;
    endtask

    typedef struct {
        bit zz, oa, td, rv, rm;
        bit tx, ul, bz;
        int fc;
    } vec_t;

    vec_t tbl[14];

    initial begin
        int lat, txc, lk, bseen, hold;

        tbl[0]  = '{1, 0, 0, 0, 0, 1, 0, 1, 0};
        tbl[1]  = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
        tbl[2]  = '{0, 0, 1, 0, 0, 0, 0, 1, 0};
        tbl[3]  = '{0, 0, 0, 1, 0, 0, 0, 1, 1};
        tbl[4]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
        tbl[5]  = '{1, 0, 0, 0, 0, 1, 0, 1, 1};
        tbl[6]  = '{0, 0, 1, 0, 0, 0, 0, 1, 1};
        tbl[7]  = '{0, 0, 0, 1, 1, 0, 1, 1, 0};
        tbl[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[9]  = '{1, 1, 0, 0, 0, 0, 0, 0, 0};
        tbl[10] = '{1, 0, 0, 0, 0, 1, 0, 1, 0};
        tbl[11] = '{0, 0, 0, 1, 1, 0, 0, 1, 0};
        tbl[12] = '{0, 1, 1, 0, 0, 0, 0, 0, 0};
        tbl[13] = '{0, 0, 0, 1, 1, 0, 0, 0, 0};

        rst_n = 0;
        step();
        step();
        check("rst_tx_en", int'(tx_en), 0);
        check("rst_unlock", int'(unlock), 0);
        check("rst_locked", int'(locked), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_fail", int'(fail_cnt), 0);
        rst_n = 1;
        step();

        for (int i = 0; i < 14; i++) begin
            zhongzhi = tbl[i].zz;
            over_all = tbl[i].oa;
            tx_done  = tbl[i].td;
            rx_valid = tbl[i].rv;
            rx_match = tbl[i].rm;
            step();
            check($sformatf("v%0d_tx_en", i), int'(tx_en), int'(tbl[i].tx));
            check($sformatf("v%0d_unlock", i), int'(unlock), int'(tbl[i].ul));
            check($sformatf("v%0d_busy", i), int'(busy), int'(tbl[i].bz));
            check($sformatf("v%0d_fail", i), int'(fail_cnt), tbl[i].fc);
            check($sformatf("v%0d_locked", i), int'(locked), 0);
        end
        zhongzhi = 0;
        over_all = 0;
        tx_done = 0;
        rx_valid = 0;
        rx_match = 0;
        step();

        // Held touch: 2 sync stages, 1 IDLE decision, SETTLE_CYC settle
        chumo = 1;
        lat = 0;
        while (!tx_en && lat < 40) begin
            step();
            lat++;
        end
        check("t1_txen_latency", lat, SETTLE_CYC + 3);
        step();
        check("t1_txen_pulse", int'(tx_en), 0);
        step();
        tx_done = 1;
        step();
        tx_done = 0;
        step();
        step();
        rx_valid = 1;
        rx_match = 1;
        step();
        rx_valid = 0;
        rx_match = 0;
        check("t1_unlock", int'(unlock), 1);
        check("t1_fail", int'(fail_cnt), 0);
        step();
        check("t1_unlock_pulse", int'(unlock), 0);
        repeat (4) step();
        check("t1_busy_held", int'(busy), 1);
        chumo = 0;
        step();
        step();
        check("t1_busy_sync", int'(busy), 1);
        step();
        check("t1_idle", int'(busy), 0);

        // Short touch aborts the settle
        chumo = 1;
        repeat (6) step();
        chumo = 0;
        txc = 0;
        bseen = 0;
        repeat (20) begin
            step();
            txc += int'(tx_en);
            bseen |= int'(busy);
        end
        check("t2_no_tx", txc, 0);
        check("t2_idle", int'(busy), 0);

        // Three rejections -> lockout
        scan(0);
        check("t3_fail1", int'(fail_cnt), 1);
        step();
        scan(0);
        check("t3_fail2", int'(fail_cnt), 2);
        step();
        scan(0);
        check("t3_fail3", int'(fail_cnt), 3);
        check("t3_locked", int'(locked), 1);
        lk = 1;
        txc = 0;
        for (int i = 1; i < 60; i++) begin
            chumo    = (i >= 3 && i <= 17);
            zhongzhi = (i >= 22 && i <= 24);
            over_all = (i == 30);
            step();
            lk += int'(locked);
            txc += int'(tx_en);
        end
        chumo = 0;
        zhongzhi = 0;
        over_all = 0;
        check("t3_lock_len", lk, LOCK_CYC);
        check("t3_no_tx", txc, 0);
        check("t3_fail_clr", int'(fail_cnt), 0);
        check("t3_idle", int'(busy), 0);

        // Manual request with no tx_done
        zhongzhi = 1;
        step();
        zhongzhi = 0;
        check("t4_tx_en", int'(tx_en), 1);
        repeat (19) step();
        check("t4_fail_before", int'(fail_cnt), 0);
        check("t4_busy", int'(busy), 1);
        step();
        check("t4_fail_after", int'(fail_cnt), 1);
        check("t4_not_locked", int'(locked), 0);
        step();
        check("t4_idle", int'(busy), 0);

        // Abort beats a same-cycle match
        zhongzhi = 1;
        step();
        zhongzhi = 0;
        tx_done = 1;
        step();
        tx_done = 0;
        rx_valid = 1;
        rx_match = 1;
        over_all = 1;
        step();
        rx_valid = 0;
        rx_match = 0;
        over_all = 0;
        check("t5_no_unlock", int'(unlock), 0);
        check("t5_idle", int'(busy), 0);
        check("t5_fail_kept", int'(fail_cnt), 1);

        // Reset in the middle of lockout
        scan(0);
        step();
        scan(0);
        check("t6_fail3", int'(fail_cnt), 3);
        repeat (5) step();
        check("t6_locked", int'(locked), 1);
        rst_n = 0;
        step();
        rst_n = 1;
        check("t6_unlocked", int'(locked), 0);
        check("t6_fail_clr", int'(fail_cnt), 0);
        check("t6_busy", int'(busy), 0);

        // Random traffic, model compares every cycle
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                chumo = ($urandom_range(0, 2) == 0);
                hold = $urandom_range(1, 25);
            end
            hold--;
            zhongzhi = ($urandom_range(0, 15) == 0);
            over_all = ($urandom_range(0, 40) == 0);
            tx_done  = ($urandom_range(0, 5) == 0);
            rx_valid = ($urandom_range(0, 6) == 0);
            rx_match = ($urandom_range(0, 2) == 0);
            rst_n    = ($urandom_range(0, 400) != 0);
            step();
        end
        rst_n = 1;
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
